// File: rtl/spi_peripheral_sync.sv
// SPI peripheral with clk-domain oversampling of cs/sck/mosi; edge events land 3 clk after the pin edge.
// Single-entry tx buffer (txReady = empty); rx word held until rxReady, overwritten with an overrun pulse.
module spi_peripheral_sync #(
  parameter int WIDTH     = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             cs,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] txData,
  input  logic             txValid,
  output logic             txReady,
  output logic [WIDTH-1:0] rxData,
  output logic             rxValid,
  input  logic             rxReady,
  output logic             overrun,
  output logic             underrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, XFER} state_t;

  state_t           state, state_nxt;
  logic             cs_s1, cs_s2, cs_h;
  logic             sck_s1, sck_s2, sck_h;
  logic             mosi_s1, mosi_s2;
  logic [WIDTH-1:0] tx_sr, tx_buf, rx_sr, rx_next;
  logic             tx_full, first_word;
  logic [CW-1:0]    bit_count;
  logic             cs_fall, cs_rise, sck_rise, sck_fall, in_frame;
  logic             sample, shift, last_bit, load, shift_bit;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_h    <= 1'b1;
      sck_s1  <= CPOL;
      sck_s2  <= CPOL;
      sck_h   <= CPOL;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_h    <= cs_s2;
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_h   <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign cs_fall  = cs_h & ~cs_s2;
  assign cs_rise  = ~cs_h & cs_s2;
  assign sck_rise = sck_s2 & ~sck_h;
  assign sck_fall = ~sck_s2 & sck_h;
  // sck is only honoured inside a frame that began with a synced cs fall
  assign in_frame  = (state != IDLE) & ~cs_s2;
  assign sample    = in_frame & ((CPOL ^ CPHA) ? sck_fall : sck_rise);
  assign shift     = in_frame & ((CPOL ^ CPHA) ? sck_rise : sck_fall);
  assign last_bit  = sample & (bit_count == CW'(WIDTH - 1));
  // In ACTIVE, a shift edge reloads unless no word has finished yet (CPHA=1 first leading edge)
  assign load      = cs_fall | (shift & (state == ACTIVE) & ~first_word);
  assign shift_bit = shift & (state == XFER);
  assign rx_next   = MSB_FIRST ? {rx_sr[WIDTH-2:0], mosi_s2} : {mosi_s2, rx_sr[WIDTH-1:1]};
  assign txReady   = ~tx_full;
  assign miso      = ~cs_s2 & (MSB_FIRST ? tx_sr[WIDTH-1] : tx_sr[0]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (sample) state_nxt = XFER;
      XFER:    if (last_bit) state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
    if (cs_rise) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tx_sr      <= '0;
      tx_buf     <= '0;
      tx_full    <= 1'b0;
      rx_sr      <= '0;
      bit_count  <= '0;
      first_word <= 1'b0;
      rxData     <= '0;
      rxValid    <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (load)           tx_sr <= tx_full ? tx_buf : '0;
      else if (shift_bit) tx_sr <= MSB_FIRST ? {tx_sr[WIDTH-2:0], 1'b0} : {1'b0, tx_sr[WIDTH-1:1]};
      else if (cs_rise)   tx_sr <= '0;
      underrun <= load & ~tx_full;

      if (load && tx_full) begin
        tx_full <= 1'b0;
      end else if (txValid && !tx_full) begin
        tx_full <= 1'b1;
        tx_buf  <= txData;
      end

      if (cs_fall)       first_word <= 1'b1;
      else if (last_bit) first_word <= 1'b0;

      if (cs_rise) begin
        rx_sr     <= '0;
        bit_count <= '0;
      end else if (sample) begin
        rx_sr     <= rx_next;
        bit_count <= last_bit ? '0 : bit_count + CW'(1);
      end

      // a completing word beats a same-cycle handshake and keeps rxValid high
      if (last_bit) begin
        rxData  <= rx_next;
        rxValid <= 1'b1;
      end else if (rxValid && rxReady) begin
        rxValid <= 1'b0;
      end
      overrun <= last_bit & rxValid & ~rxReady;
    end
  end

endmodule
